// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready stream carrying a WIDTH-bit stage payload
//   valid  producer -> consumer  beat valid
//   ready  consumer -> producer  consumer accepts the beat
//   data   producer -> consumer  payload
interface pipe_stage_buf_if #(parameter int WIDTH = 64);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;
   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with flush and optional skid entry
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   flush   kills held entries and any beat accepted this cycle
//   in_if   upstream stream (slave): in_valid / in_ready / in_data
//   out_if  downstream stream (master): out_valid / out_ready / out_data
//   count   occupancy 0..2 (0..1 when SKID=0)
module pipe_stage_buf #(
   parameter int               WIDTH    = 64,
   parameter bit               SKID     = 1'b1,
   parameter logic [WIDTH-1:0] RST_DATA = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   pipe_stage_buf_if.slave        in_if,
   pipe_stage_buf_if.master       out_if,
   output logic [1:0]             count
);
   if (SKID) begin : g_skid
      typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
      state_e           state_q, state_d;
      logic             rdy_q;
      logic [WIDTH-1:0] m_q, m_d, s_q, s_d;
      logic             in_fire, out_fire;
      assign in_fire  = in_if.valid & rdy_q;
      assign out_fire = (state_q != EMPTY) & out_if.ready;
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
            m_q     <= RST_DATA;
            s_q     <= RST_DATA;
         end else begin
            state_q <= state_d;
            rdy_q   <= state_d != TWO;
            m_q     <= m_d;
            s_q     <= s_d;
         end
      end
      always_comb begin
         state_d = state_q;
         m_d     = m_q;
         s_d     = s_q;
         case (state_q)
            EMPTY: if (in_fire) begin
               m_d     = in_if.data;
               state_d = ONE;
            end
            ONE: if (in_fire && out_fire) m_d = in_if.data;
            else if (in_fire) begin
               s_d     = in_if.data;
               state_d = TWO;
            end else if (out_fire) state_d = EMPTY;
            TWO: if (out_fire) begin
               m_d     = s_q;
               state_d = ONE;
            end
            default: state_d = EMPTY;
         endcase
         // flush keeps data regs untouched so out_data stays stable while idle
         if (flush) begin
            state_d = EMPTY;
            m_d     = m_q;
            s_d     = s_q;
         end
      end
      always_comb begin
         out_if.valid = state_q != EMPTY;
         out_if.data  = m_q;
         in_if.ready  = rdy_q;
         count        = state_q;
      end
   end else begin : g_reg
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] m_q, m_d;
      logic             in_fire, out_fire;
      // ready looks through a departing beat, giving back-to-back transfers
      assign in_fire  = in_if.valid & (~valid_q | out_if.ready);
      assign out_fire = valid_q & out_if.ready;
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            m_q     <= RST_DATA;
         end else begin
            valid_q <= valid_d;
            m_q     <= m_d;
         end
      end
      always_comb begin
         valid_d = flush ? 1'b0 : in_fire ? 1'b1 : out_fire ? 1'b0 : valid_q;
         m_d     = (in_fire && !flush) ? in_if.data : m_q;
      end
      always_comb begin
         out_if.valid = valid_q;
         out_if.data  = m_q;
         in_if.ready  = ~valid_q | out_if.ready;
         count        = {1'b0, valid_q};
      end
   end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: checks SKID=0 and SKID=1 instances against a queue model
module tb_pipe_stage_buf;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        iv = 1'b0;
   logic        ordy = 1'b0;
   logic [63:0] id = '0;
   int          passed = 0;
   int          total = 0;
   logic [63:0] q [2][$];
   logic        rdy [2];
   logic        ov [2];
   logic [63:0] od [2];
   logic [1:0]  cnt [2];

   always #5 clk = ~clk;

   pipe_stage_buf_if #(.WIDTH(64)) a_in ();
   pipe_stage_buf_if #(.WIDTH(64)) a_out ();
   pipe_stage_buf_if #(.WIDTH(64)) b_in ();
   pipe_stage_buf_if #(.WIDTH(64)) b_out ();

   assign a_in.valid  = iv;
   assign a_in.data   = id;
   assign a_out.ready = ordy;
   assign b_in.valid  = iv;
   assign b_in.data   = id;
   assign b_out.ready = ordy;
   assign rdy[0] = a_in.ready;
   assign ov[0]  = a_out.valid;
   assign od[0]  = a_out.data;
   assign rdy[1] = b_in.ready;
   assign ov[1]  = b_out.valid;
   assign od[1]  = b_out.data;

   pipe_stage_buf #(.WIDTH(64), .SKID(1'b0)) u_reg (
      .clk(clk), .rst(rst), .flush(flush), .in_if(a_in), .out_if(a_out), .count(cnt[0]));
   pipe_stage_buf #(.WIDTH(64), .SKID(1'b1)) u_skid (
      .clk(clk), .rst(rst), .flush(flush), .in_if(b_in), .out_if(b_out), .count(cnt[1]));

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, o, e);
   endtask

   // model: SKID=1 holds up to two beats, ready when not full;
   // SKID=0 holds one beat, ready when empty or the held beat leaves now
   task automatic step(input logic v, input logic [63:0] d, input logic r, input logic f);
      logic erdy [2];
      logic eov [2];
      @(negedge clk);
      iv = v; id = d; ordy = r; flush = f;
      #1;
      for (int k = 0; k < 2; k++) begin
         eov[k]  = q[k].size() > 0;
         erdy[k] = k == 1 ? q[k].size() < 2 : (q[k].size() == 0 || r);
         chk($sformatf("skid%0d_in_ready", k), 64'(rdy[k]), 64'(erdy[k]));
         chk($sformatf("skid%0d_out_valid", k), 64'(ov[k]), 64'(eov[k]));
         chk($sformatf("skid%0d_count", k), 64'(cnt[k]), 64'(q[k].size()));
         if (eov[k]) chk($sformatf("skid%0d_out_data", k), od[k], q[k][0]);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (f) q[k].delete();
         else begin
            if (eov[k] && r) void'(q[k].pop_front());
            if (v && erdy[k]) q[k].push_back(d);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; iv = 1'b1; id = 64'hAA; ordy = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      q[0].delete();
      q[1].delete();
      @(negedge clk);
      rst = 1'b0; iv = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst%0d_out_valid", k), 64'(ov[k]), 64'd0);
         chk($sformatf("rst%0d_count", k), 64'(cnt[k]), 64'd0);
         chk($sformatf("rst%0d_in_ready", k), 64'(rdy[k]), 64'd1);
         chk($sformatf("rst%0d_out_data", k), od[k], 64'd0);
      end
   endtask

   initial begin
      do_reset();
      step(1, 64'h1, 1, 0);
      step(1, 64'h2, 1, 0);
      step(1, 64'h3, 1, 0);
      step(1, 64'h4, 1, 0);
      step(0, 64'h0, 1, 0);
      step(0, 64'h0, 1, 0);
      step(1, 64'h10, 0, 0);
      step(1, 64'h20, 0, 0);
      step(0, 64'h0, 0, 0);
      step(0, 64'h0, 1, 0);
      step(0, 64'h0, 1, 0);
      step(0, 64'h0, 1, 0);
      step(1, 64'h5, 0, 0);
      step(1, 64'h6, 1, 0);
      step(0, 64'h0, 0, 0);
      step(0, 64'h0, 1, 0);
      step(1, 64'h7, 0, 0);
      step(1, 64'h8, 0, 0);
      step(1, 64'h9, 0, 1);
      step(0, 64'h0, 1, 0);
      step(1, 64'hA, 0, 0);
      step(1, 64'hC, 0, 1);
      step(0, 64'h0, 1, 0);
      step(1, 64'hA0, 0, 0);
      step(1, 64'hB, 1, 0);
      step(0, 64'h0, 1, 0);
      step(0, 64'h0, 1, 0);
      for (int n = 0; n < 400; n++)
         step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0);
      do_reset();
      step(0, 64'h0, 1, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
